alu_share_arbiter: RTL

//  Shares the single 8-bit ALU between two requesters: the core datapath (req0) and the debug/test port (req1).

---
 rtl/alu_share_arbiter_if.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle between the two ALU requesters, the response consumer and the shared ALU.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if #(
    parameter int DW  = 8,
    parameter int OPW = 3
);
    // Every channel transfers on a rising edge where valid and ready are both high;
    // once raised, rsp_valid and its payload hold until that transfer.
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [DW-1:0]  rsp_data;
    logic           rsp_jump;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_in1;
    logic [DW-1:0]  alu_in2;
    logic [DW-1:0]  alu_out;
    logic           alu_jump;
    logic           busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready, alu_out, alu_jump,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_jump,
        output alu_op, alu_in1, alu_in2, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready, alu_out, alu_jump,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_jump,
        input  alu_op, alu_in1, alu_in2, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of a single combinational ALU: one op in flight,
// IDLE -> EXEC -> RESP, result returned on a tagged response channel.
module alu_share_arbiter #(
    parameter int DW        = 8,
    parameter int OPW       = 3,
    parameter int PRIO_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus,
    output logic [1:0]          o_dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic           r_grant_id;
    logic [OPW-1:0] r_alu_op;
    logic [DW-1:0]  r_alu_in1;
    logic [DW-1:0]  r_alu_in2;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [DW-1:0]  r_rsp_data;
    logic           r_rsp_jump;

    logic           w_sel;
    logic           w_req0_ready;
    logic           w_req1_ready;
    logic           w_accept;
    logic [OPW-1:0] w_op;
    logic [DW-1:0]  w_a;
    logic [DW-1:0]  w_b;

    // A lone requester always wins; contention is settled by mode and last grant.
    always_comb begin
        w_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            w_sel = (PRIO_MODE == 1) ? 1'b0 : ~r_last_grant;
        else if (bus.req1_valid)
            w_sel = 1'b1;
        w_req0_ready = (r_state == ST_IDLE) && bus.req0_valid && !w_sel;
        w_req1_ready = (r_state == ST_IDLE) && bus.req1_valid && w_sel;
        w_accept     = w_req0_ready || w_req1_ready;
        w_op         = w_sel ? bus.req1_op : bus.req0_op;
        w_a          = w_sel ? bus.req1_a  : bus.req0_a;
        w_b          = w_sel ? bus.req1_b  : bus.req0_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_alu_op     <= '0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_jump   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_op     <= w_op;
                        r_alu_in1    <= w_a;
                        r_alu_in2    <= w_b;
                        r_grant_id   <= w_sel;
                        r_last_grant <= w_sel;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= bus.alu_out;
                    r_rsp_jump  <= bus.alu_jump;
                    r_rsp_id    <= r_grant_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_jump   = r_rsp_jump;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_in1    = r_alu_in1;
    assign bus.alu_in2    = r_alu_in2;
    assign bus.busy       = (r_state == ST_EXEC) || (r_state == ST_RESP);
    assign o_dbg_state    = r_state;
endmodule
